pipe_hazard_ctrl: RTL and testbench

- Sequencing controller for the 5-stage LEGv8 pipeline (IF/ID/EX/MEM/WB).
- Takes the ID-stage control word from the instruction decoder and keeps its own shadow copy of the EX and MEM stage controls.
- Generates PC/pipeline-register write enables, bubbles and flushes for three cases: load-use hazards, taken CBZ branches resolved in MEM, and a multi-cycle data-memory handshake.
- Counts stall and flush cycles for performance visibility.

---
 rtl/lgv_pipe_pkg.sv | 29 ++
 rtl/pipe_hazard_cmp.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lgv_pipe_pkg.sv
// Shared LEGv8 pipeline types and constants.
// Used by the decoder and the hazard/sequencing control.
package lgv_pipe_pkg;

  localparam logic [4:0] XZR = 5'd31;

  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       mem_access;
    logic       branch;
  } stage_ctrl_t;

  typedef enum logic {
    MS_IDLE = 1'b0,
    MS_WAIT = 1'b1
  } mem_st_e;

endpackage

// File: rtl/pipe_hazard_cmp.sv
// RAW comparator: does the ID instruction read what a
// shadowed older stage is about to write?
module pipe_hazard_cmp
  import lgv_pipe_pkg::*;
(
  input  logic       st_valid,
  input  logic       st_reg_write,
  input  logic [4:0] st_rd,
  input  logic [4:0] id_rn,
  input  logic [4:0] id_r2,
  input  logic       id_use_rn,
  input  logic       id_use_r2,
  output logic       hit
);

  logic rn_eq;
  logic r2_eq;

  assign rn_eq = id_use_rn & (id_rn == st_rd);
  assign r2_eq = id_use_r2 & (id_r2 == st_rd);

  // XZR reads as zero, so writing it never feeds anyone
  assign hit = st_valid & st_reg_write &
               (st_rd != XZR) & (rn_eq | r2_eq);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// LEGv8 5-stage sequencing: load-use stalls, CBZ flushes,
// multi-cycle data-memory freeze and perf counters.
module pipe_hazard_ctrl
  import lgv_pipe_pkg::*;
#(
  parameter bit FWD_EN      = 1'b1,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_r2,
  input  logic             id_use_rn,
  input  logic             id_use_r2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_branch,
  input  logic             mem_zero,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             pipe_en,
  output logic             idex_bubble,
  output logic             flush,
  output logic             pc_src,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST =
    WC_W'(MEM_TIMEOUT - 1);
  localparam logic [WC_W-1:0]  WC_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  stage_ctrl_t ex_q, ex_d;
  stage_ctrl_t mem_q, mem_d;
  stage_ctrl_t id_ctrl;
  mem_st_e     st_q, st_d;

  logic [WC_W-1:0]  wc_q, wc_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic hit_ex;
  logic hit_mem;
  logic hazard;
  logic taken;
  logic mem_hit;
  logic freeze;
  logic unused_ok;

  pipe_hazard_cmp u_cmp_ex (
    .st_valid     (ex_q.valid),
    .st_reg_write (ex_q.reg_write),
    .st_rd        (ex_q.rd),
    .id_rn        (id_rn),
    .id_r2        (id_r2),
    .id_use_rn    (id_use_rn),
    .id_use_r2    (id_use_r2),
    .hit          (hit_ex)
  );

  pipe_hazard_cmp u_cmp_mem (
    .st_valid     (mem_q.valid),
    .st_reg_write (mem_q.reg_write),
    .st_rd        (mem_q.rd),
    .id_rn        (id_rn),
    .id_r2        (id_r2),
    .id_use_rn    (id_use_rn),
    .id_use_r2    (id_use_r2),
    .hit          (hit_mem)
  );

  assign unused_ok = mem_q.mem_read;

  assign hazard = id_valid &
    (FWD_EN ? (ex_q.mem_read & hit_ex)
            : (hit_ex | hit_mem));

  assign taken   = mem_q.valid & mem_q.branch & mem_zero;
  assign mem_hit = mem_q.valid & mem_q.mem_access;

  always_comb begin
    id_ctrl.valid      = id_valid;
    id_ctrl.rd         = id_rd;
    id_ctrl.reg_write  = id_reg_write;
    id_ctrl.mem_read   = id_mem_read;
    id_ctrl.mem_access = id_mem_read | id_mem_write;
    id_ctrl.branch     = id_branch;
  end

  always_comb begin
    st_d     = st_q;
    wc_d     = wc_q;
    err_d    = err_q;
    freeze   = 1'b0;
    dmem_req = 1'b0;
    unique case (st_q)
      MS_IDLE: begin
        dmem_req = mem_hit;
        if (mem_hit && !dmem_ready) begin
          freeze = 1'b1;
          st_d   = MS_WAIT;
          wc_d   = '0;
        end
      end
      MS_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          st_d = MS_IDLE;
        end else if (wc_q == WC_LAST) begin
          // give up: drop the access and let the pipe move
          err_d = 1'b1;
          st_d  = MS_IDLE;
        end else begin
          freeze = 1'b1;
          wc_d   = wc_q + WC_ONE;
        end
      end
      default: st_d = MS_IDLE;
    endcase
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    pipe_en     = 1'b1;
    idex_bubble = 1'b0;
    flush       = 1'b0;
    pc_src      = 1'b0;
    priority case (1'b1)
      freeze: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        pipe_en    = 1'b0;
      end
      taken: begin
        flush  = 1'b1;
        pc_src = 1'b1;
      end
      hazard: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    if (pipe_en) begin
      // the squashed EX instruction reaches MEM with no controls
      mem_d = flush ? '0 : ex_q;
      ex_d  = (idex_bubble || flush) ? '0 : id_ctrl;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if ((freeze || idex_bubble) && !(&stall_q))
      stall_d = stall_q + CNT_ONE;
    if (flush && !(&flush_q))
      flush_d = flush_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      st_q    <= MS_IDLE;
      wc_q    <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      st_q    <= st_d;
      wc_q    <= wc_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign mem_err   = err_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: per-cycle vector tables with a
// scoreboard queue, plus hand-run reset corner cases.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rn;
    logic [4:0] r2;
    logic       urn;
    logic       ur2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       mw;
    logic       br;
  } id_t;

  typedef struct {
    id_t        id;
    logic       mz;
    logic       rdy;
    logic [7:0] exp;
    bit         chk0;
    logic [7:0] exp0;
  } vec_t;

  typedef struct {
    logic [7:0] exp;
    bit         chk0;
    logic [7:0] exp0;
    int         idx;
  } sb_t;

  // {pc_write,ifid_write,pipe_en,bubble,flush,pc_src,req,err}
  localparam logic [7:0] N  = 8'b1110_0000;
  localparam logic [7:0] NR = 8'b1110_0010;
  localparam logic [7:0] H  = 8'b0011_0000;
  localparam logic [7:0] F  = 8'b1110_1100;
  localparam logic [7:0] Z  = 8'b0000_0010;
  localparam logic [7:0] NE = 8'b1110_0001;

  logic clk;
  logic rst_n;
  id_t  cur;
  logic mz;
  logic rdy;

  logic        req_a, pcw_a, ifw_a, pen_a;
  logic        bub_a, fl_a, src_a, err_a;
  logic [15:0] sc_a, fc_a;
  logic        req_b, pcw_b, ifw_b, pen_b;
  logic        bub_b, fl_b, src_b, err_b;
  logic [15:0] sc_b, fc_b;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   n_chk;
  int   n_fail;

  pipe_hazard_ctrl #(
    .FWD_EN(1'b1), .CNT_W(16), .MEM_TIMEOUT(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(cur.v), .id_rn(cur.rn), .id_r2(cur.r2),
    .id_use_rn(cur.urn), .id_use_r2(cur.ur2),
    .id_rd(cur.rd), .id_reg_write(cur.rw),
    .id_mem_read(cur.mr), .id_mem_write(cur.mw),
    .id_branch(cur.br), .mem_zero(mz), .dmem_ready(rdy),
    .dmem_req(req_a), .pc_write(pcw_a),
    .ifid_write(ifw_a), .pipe_en(pen_a),
    .idex_bubble(bub_a), .flush(fl_a), .pc_src(src_a),
    .mem_err(err_a), .stall_cnt(sc_a), .flush_cnt(fc_a)
  );

  pipe_hazard_ctrl #(
    .FWD_EN(1'b0), .CNT_W(16), .MEM_TIMEOUT(4)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .id_valid(cur.v), .id_rn(cur.rn), .id_r2(cur.r2),
    .id_use_rn(cur.urn), .id_use_r2(cur.ur2),
    .id_rd(cur.rd), .id_reg_write(cur.rw),
    .id_mem_read(cur.mr), .id_mem_write(cur.mw),
    .id_branch(cur.br), .mem_zero(mz), .dmem_ready(rdy),
    .dmem_req(req_b), .pc_write(pcw_b),
    .ifid_write(ifw_b), .pipe_en(pen_b),
    .idex_bubble(bub_b), .flush(fl_b), .pc_src(src_b),
    .mem_err(err_b), .stall_cnt(sc_b), .flush_cnt(fc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic id_t nop();
    return '0;
  endfunction

  function automatic id_t ldur(logic [4:0] rt, logic [4:0] rn);
    id_t i = '0;
    i.v = 1; i.rn = rn; i.urn = 1; i.rd = rt;
    i.rw = 1; i.mr = 1;
    return i;
  endfunction

  function automatic id_t stur(logic [4:0] rt, logic [4:0] rn);
    id_t i = '0;
    i.v = 1; i.rn = rn; i.r2 = rt;
    i.urn = 1; i.ur2 = 1; i.mw = 1;
    return i;
  endfunction

  function automatic id_t addr(logic [4:0] rd, logic [4:0] rn,
                               logic [4:0] rm);
    id_t i = '0;
    i.v = 1; i.rn = rn; i.r2 = rm;
    i.urn = 1; i.ur2 = 1; i.rd = rd; i.rw = 1;
    return i;
  endfunction

  function automatic id_t cbz(logic [4:0] rt);
    id_t i = '0;
    i.v = 1; i.r2 = rt; i.ur2 = 1; i.br = 1;
    return i;
  endfunction

  function automatic void row(id_t id, logic m, logic r,
                              logic [7:0] e, bit c0 = 1'b0,
                              logic [7:0] e0 = 8'h00);
    tbl.push_back('{id, m, r, e, c0, e0});
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] outs_a();
    return {pcw_a, ifw_a, pen_a, bub_a, fl_a, src_a,
            req_a, err_a};
  endfunction

  function automatic logic [7:0] outs_b();
    return {pcw_b, ifw_b, pen_b, bub_b, fl_b, src_b,
            req_b, err_b};
  endfunction

  task automatic run_tbl(input string t);
    sb_t s;
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      cur = tbl[i].id;
      mz  = tbl[i].mz;
      rdy = tbl[i].rdy;
      sbq.push_back('{tbl[i].exp, tbl[i].chk0,
                      tbl[i].exp0, i});
      @(negedge clk);
      s = sbq.pop_front();
      check($sformatf("%s[%0d]", t, s.idx),
            32'(outs_a()), 32'(s.exp));
      if (s.chk0)
        check($sformatf("%s_nofwd[%0d]", t, s.idx),
              32'(outs_b()), 32'(s.exp0));
    end
    tbl.delete();
  endtask

  task automatic do_reset(input string t);
    @(posedge clk);
    #1;
    cur   = nop();
    mz    = 1'b0;
    rdy   = 1'b1;
    rst_n = 1'b0;
    #2;
    check({t, "_rst_out"}, 32'(outs_a()), 32'(N));
    check({t, "_rst_out0"}, 32'(outs_b()), 32'(N));
    check({t, "_rst_cnt"}, {sc_a, fc_a}, 32'h0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    cur    = '0;
    mz     = 1'b0;
    rdy    = 1'b1;

    do_reset("init");
    row(ldur(1, 5),    0, 1, N,  1, N);
    row(addr(2, 1, 3), 0, 1, H,  1, H);
    row(addr(2, 1, 3), 0, 1, NR);
    row(nop(),         0, 1, N);
    run_tbl("loaduse");
    check("loaduse_stall", 32'(sc_a), 32'd1);

    do_reset("xzr");
    row(ldur(31, 5),     0, 1, N,  1, N);
    row(addr(2, 31, 31), 0, 1, N,  1, N);
    row(nop(),           0, 1, NR, 1, NR);
    run_tbl("xzr");
    check("xzr_stall", 32'(sc_a), 32'd0);

    do_reset("alu");
    row(addr(1, 2, 3), 0, 1, N, 1, N);
    row(addr(4, 1, 1), 0, 1, N, 1, H);
    row(addr(4, 1, 1), 0, 1, N, 1, H);
    row(addr(4, 1, 1), 0, 1, N, 1, N);
    row(nop(),         0, 1, N, 1, N);
    run_tbl("alu");
    check("alu_stall_fwd", 32'(sc_a), 32'd0);
    check("alu_stall_nofwd", 32'(sc_b), 32'd2);

    do_reset("cbz");
    row(cbz(7),        0, 1, N, 1, N);
    row(ldur(1, 5),    0, 1, N, 1, N);
    row(addr(2, 1, 3), 1, 1, F, 1, F);
    row(nop(),         1, 1, N, 1, N);
    run_tbl("cbz_taken");
    check("cbz_flushcnt", 32'(fc_a), 32'd1);
    row(cbz(7), 0, 1, N);
    row(nop(),  0, 1, N);
    row(nop(),  0, 1, N);
    row(nop(),  1, 1, N);
    run_tbl("cbz_nt");
    check("cbz_nt_flushcnt", 32'(fc_a), 32'd1);

    do_reset("mwait");
    row(stur(3, 5), 0, 1, N);
    row(nop(),      0, 1, N);
    row(nop(),      0, 0, Z);
    row(nop(),      0, 0, Z);
    row(nop(),      0, 0, Z);
    row(nop(),      0, 1, NR);
    row(nop(),      0, 1, N);
    run_tbl("mwait");
    check("mwait_stall", 32'(sc_a), 32'd3);

    do_reset("tmo");
    row(stur(3, 5), 0, 1, N);
    row(nop(),      0, 1, N);
    row(nop(),      0, 0, Z);
    row(nop(),      0, 0, Z);
    row(nop(),      0, 0, Z);
    row(nop(),      0, 0, Z);
    row(nop(),      0, 0, NR);
    row(nop(),      0, 0, NE);
    row(nop(),      0, 1, NE);
    run_tbl("tmo");
    check("tmo_stall", 32'(sc_a), 32'd4);

    do_reset("rstwait");
    row(stur(3, 5), 0, 1, N);
    row(nop(),      0, 1, N);
    row(nop(),      0, 0, Z);
    row(nop(),      0, 0, Z);
    run_tbl("rstwait");
    #1;
    rst_n = 1'b0;
    #1;
    check("rstwait_out", 32'(outs_a()), 32'(N));
    check("rstwait_cnt", 32'(sc_a), 32'd0);
    #1;
    rst_n = 1'b1;
    row(addr(2, 1, 3), 0, 0, N);
    row(nop(),         0, 0, N);
    run_tbl("postrst");
    check("postrst_stall", 32'(sc_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
